yutorina_pipe_ctrl: RTL
=======================

// Module: yutorina_pipe_ctrl
// PURPOSE
//  - Pipeline sequencer for the IF/ID/EX/MEM pipeline: produces per-stage stall/flush and the redirect PC.
//  - Handles load-use bubbles, bus-busy freezes, exception/IRQ entry and ERET.
//  - Owns the exception SPRs (STATUS, PRE_STATUS, EPC, EXP_CODE, INT_MASK) and drives the decode-stage mode.
// PARAMETERS
//  ADDR_W   30          word-address width of PCs
//  EXP_W    3           exception-code width; code 0 = EXP_NONE
//  IRQ_CH   8           external interrupt lines
//  EXC_VEC  30'h0000100 trap-handler word address
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  if_busy        in   1       IF bus access pending
//  mem_busy       in   1       MEM bus access pending
//  ld_haz         in   1       ID holds a load whose result the next instruction needs
//  mem_en_        in   1       MEM-stage slot valid, active-low
//  mem_pc         in   ADDR_W  PC of the MEM-stage instruction
//  mem_exp_code   in   EXP_W   exception raised by the MEM-stage instruction
//  mem_eret       in   1       MEM-stage instruction is ERET
//  irq            in   IRQ_CH  level-sensitive interrupt requests
//  spr_we_        in   1       SPR write strobe, active-low (from MEM)
//  spr_w_addr     in   3       SPR write index
//  spr_w_data     in   32      SPR write data
//  spr_r_addr     in   3       SPR read index (from ID)
//  spr_r_data     out  32      combinational SPR read data
//  if_stall, id_stall, ex_stall, mem_stall      out 1 each  hold the stage register
//  if_flush, id_flush, ex_flush, mem_flush      out 1 each  load a bubble into the stage register
//  new_pc         out  ADDR_W  redirect target, valid while if_flush=1
//  mode           out  1       0 = kernel, 1 = user
// BEHAVIOUR
//  - SPR indices: 0 STATUS{ie[1], mode[0]}; 1 PRE_STATUS; 2 EPC (ADDR_W, zero-extended); 3 EXP_CODE; 4 INT_MASK (1 = masked); 5-7 read 0, writes ignored.
//  - Reset: every stall/flush output 0; new_pc = 0; STATUS = {ie=0, mode=0}; PRE_STATUS = 0; EPC = 0; EXP_CODE = 0; INT_MASK = all ones; state = RUN.
//  - FSM states: RUN, TRAP, RETURN.
//    - TRAP and RETURN last exactly one cycle each, then go to RUN.
//    - These two states drive if_stall=1 so the redirected fetch settles; all other controls are 0.
//  - Priority in RUN, highest first, evaluated each cycle:
//    1. busy = if_busy | mem_busy:
//       - all four stall outputs = 1, all flushes = 0.
//       - No SPR update, no state change; a pending exception waits.
//    2. Exception, when mem_en_ = 0 and (mem_exp_code != 0 or an IRQ is taken):
//       - IRQ taken = ie & |(irq & ~INT_MASK). A nonzero mem_exp_code wins over an IRQ; an IRQ records code 1 (EXP_EXT_INT).
//       - Combinational outputs: all four flushes = 1; new_pc = EXC_VEC.
//       - Next edge: EPC <= mem_pc; EXP_CODE <= code; PRE_STATUS <= STATUS; STATUS <= {0, 0}; state <= TRAP.
//    3. ERET, when mem_en_ = 0 and mem_eret = 1:
//       - Combinational outputs: all flushes = 1; new_pc = EPC.
//       - Next edge: STATUS <= PRE_STATUS; state <= RETURN.
//    4. ld_haz: if_stall = 1 and id_flush = 1 for that cycle only (one bubble). id_stall = 0.
//    5. Otherwise all stall and flush outputs are 0.
//  - SPR write:
//    - Applies on the edge when spr_we_ = 0 and busy = 0.
//    - Exception or ERET on the same cycle overrides any write to STATUS/PRE_STATUS/EPC/EXP_CODE.
//  - spr_r_data: reads the current registered value; no bypass of a same-cycle write.
//  - mode: always equals STATUS.mode.
//  - Reset asserted mid-TRAP/RETURN: returns to RUN with reset values on the next edge.
//  - Busy is ignored in TRAP/RETURN; the one-cycle advance still occurs.
// CONFIGURATION
//  - YUTORINA_PIPE_CTRL_IRQ_EN defined:
//    - irq/INT_MASK path active as described.
//  - YUTORINA_PIPE_CTRL_IRQ_EN undefined:
//    - irq port remains but is ignored; INT_MASK reads 0 and is not writable.
//    - STATUS.ie remains read/writable but has no effect.
//    - Only mem_exp_code causes traps.
// STRUCTURE
//  - Shared header pipe_ctrl.h:
//    - State encodings (ST_RUN/ST_TRAP/ST_RETURN).
//    - SPR index constants.
//    - EXP_NONE/EXP_EXT_INT codes.
//    - MODE_KERNEL/MODE_USER.
//    - EXC_VEC default.
//  - One sub-module yutorina_exc_spr: SPR register file plus read mux.
//  - The FSM and stall/flush logic stay in this module.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> all stall/flush outputs 0, mode=0, spr_r_addr=4 reads 32'hFF.
//  2. ld_haz=1 one cycle -> if_stall=1, id_flush=1 that cycle; the next cycle all controls 0.
//  3. mem_en_=0, mem_exp_code=3, mem_pc=30'h40 ->
//     - that cycle: all flushes=1, new_pc=EXC_VEC;
//     - next cycle: EPC=30'h40, EXP_CODE=3, mode=0, state TRAP with if_stall=1.
//  4. ERET after the trap, with PRE_STATUS=2'b11 -> new_pc=30'h40 and flushes=1; next cycle mode=1, ie=1.
//  5. mem_busy=1 held 3 cycles with an exception pending -> stalls=1, no flush; the trap fires on the first non-busy cycle.
//  6. (IRQ_EN) ie=1, INT_MASK=8'hFE, irq=8'h01 on a valid MEM slot -> trap, EXP_CODE=1.
//     - Same with INT_MASK=8'hFF -> no trap.

Source files
------------

// File: rtl/yutorina_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Define YUTORINA_PIPE_CTRL_IRQ_EN to enable external interrupt handling.
package yutorina_pipe_ctrl_pkg;

    localparam int ADDR_W = 30;
    localparam int EXP_W  = 3;
    localparam int IRQ_CH = 8;

    localparam logic [ADDR_W-1:0] EXC_VEC = 30'h0000100;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_TRAP   = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

    localparam logic [2:0] SPR_STATUS     = 3'd0;
    localparam logic [2:0] SPR_PRE_STATUS = 3'd1;
    localparam logic [2:0] SPR_EPC        = 3'd2;
    localparam logic [2:0] SPR_EXP_CODE   = 3'd3;
    localparam logic [2:0] SPR_INT_MASK   = 3'd4;

    localparam logic [EXP_W-1:0] EXP_NONE    = 3'd0;
    localparam logic [EXP_W-1:0] EXP_EXT_INT = 3'd1;

    localparam logic MODE_KERNEL = 1'b0;
    localparam logic MODE_USER   = 1'b1;

    typedef struct packed {
        logic ie;
        logic mode;
    } status_t;

endpackage

// File: rtl/yutorina_pipe_ctrl_if.sv
// Pipeline-facing bundle of the sequencer: hazard/exception inputs,
// SPR access and per-stage stall/flush/redirect outputs.
interface yutorina_pipe_ctrl_if;
    import yutorina_pipe_ctrl_pkg::*;

    logic              if_busy;
    logic              mem_busy;
    logic              ld_haz;
    logic              mem_en_;
    logic [ADDR_W-1:0] mem_pc;
    logic [EXP_W-1:0]  mem_exp_code;
    logic              mem_eret;
    logic [IRQ_CH-1:0] irq;
    logic              spr_we_;
    logic [2:0]        spr_w_addr;
    logic [31:0]       spr_w_data;
    logic [2:0]        spr_r_addr;
    logic [31:0]       spr_r_data;
    logic              if_stall, id_stall, ex_stall, mem_stall;
    logic              if_flush, id_flush, ex_flush, mem_flush;
    logic [ADDR_W-1:0] new_pc;
    logic              mode;

    modport master (
        output if_busy, mem_busy, ld_haz, mem_en_, mem_pc,
        output mem_exp_code, mem_eret, irq,
        output spr_we_, spr_w_addr, spr_w_data, spr_r_addr,
        input  spr_r_data,
        input  if_stall, id_stall, ex_stall, mem_stall,
        input  if_flush, id_flush, ex_flush, mem_flush,
        input  new_pc, mode
    );

    modport slave (
        input  if_busy, mem_busy, ld_haz, mem_en_, mem_pc,
        input  mem_exp_code, mem_eret, irq,
        input  spr_we_, spr_w_addr, spr_w_data, spr_r_addr,
        output spr_r_data,
        output if_stall, id_stall, ex_stall, mem_stall,
        output if_flush, id_flush, ex_flush, mem_flush,
        output new_pc, mode
    );

endinterface

// File: rtl/yutorina_exc_spr.sv
// Exception SPR file (STATUS, PRE_STATUS, EPC, EXP_CODE, INT_MASK).
// INT_MASK only exists with YUTORINA_PIPE_CTRL_IRQ_EN; otherwise it reads 0.
module yutorina_exc_spr
    import yutorina_pipe_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              trap_i,
    input  logic [EXP_W-1:0]  code_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              eret_i,
    input  logic [2:0]        raddr_i,
    output logic [31:0]       rdata_o,
    output status_t           status_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic [IRQ_CH-1:0] mask_o
);

    status_t           status_q, status_d;
    status_t           pre_q, pre_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [EXP_W-1:0]  code_q, code_d;
    logic [IRQ_CH-1:0] mask_q;

    // Trap/ERET commit overrides a same-cycle software write.
    always_comb begin
        status_d = status_q;
        pre_d    = pre_q;
        epc_d    = epc_q;
        code_d   = code_q;
        if (we_i) begin
            unique case (waddr_i)
                SPR_STATUS:     status_d = status_t'(wdata_i[1:0]);
                SPR_PRE_STATUS: pre_d    = status_t'(wdata_i[1:0]);
                SPR_EPC:        epc_d    = wdata_i[ADDR_W-1:0];
                SPR_EXP_CODE:   code_d   = wdata_i[EXP_W-1:0];
                default: ;
            endcase
        end
        if (trap_i) begin
            epc_d    = pc_i;
            code_d   = code_i;
            pre_d    = status_q;
            status_d = '0;
        end else if (eret_i) begin
            status_d = pre_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
            pre_q    <= '0;
            epc_q    <= '0;
            code_q   <= EXP_NONE;
        end else begin
            status_q <= status_d;
            pre_q    <= pre_d;
            epc_q    <= epc_d;
            code_q   <= code_d;
        end
    end

`ifdef YUTORINA_PIPE_CTRL_IRQ_EN
    logic [IRQ_CH-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        if (we_i && waddr_i == SPR_INT_MASK)
            mask_d = wdata_i[IRQ_CH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) mask_q <= '1;
        else       mask_q <= mask_d;
    end
`else
    assign mask_q = '0;
`endif

    always_comb begin
        rdata_o = '0;
        unique case (raddr_i)
            SPR_STATUS:     rdata_o = 32'(status_q);
            SPR_PRE_STATUS: rdata_o = 32'(pre_q);
            SPR_EPC:        rdata_o = 32'(epc_q);
            SPR_EXP_CODE:   rdata_o = 32'(code_q);
            SPR_INT_MASK:   rdata_o = 32'(mask_q);
            default:        rdata_o = '0;
        endcase
    end

    assign status_o = status_q;
    assign epc_o    = epc_q;
    assign mask_o   = mask_q;

endmodule

// File: rtl/yutorina_pipe_ctrl.sv
// Pipeline sequencer: stage stall/flush, redirect PC and trap/ERET FSM.
// Build with YUTORINA_PIPE_CTRL_IRQ_EN to let irq lines raise traps.
module yutorina_pipe_ctrl
    import yutorina_pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    yutorina_pipe_ctrl_if.slave  bus
);

    state_e            state_q;
    status_t           status;
    logic [ADDR_W-1:0] epc;
    logic [IRQ_CH-1:0] mask;
    logic              busy, irq_take, exc, eret;
    logic              sel_busy, sel_exc, sel_eret, sel_ld;
    logic              run, trap_go, eret_go;
    logic [EXP_W-1:0]  code;
    logic [3:0]        stall, flush;
    logic [ADDR_W-1:0] new_pc;

    assign busy = bus.if_busy | bus.mem_busy;

`ifdef YUTORINA_PIPE_CTRL_IRQ_EN
    assign irq_take = status.ie & |(bus.irq & ~mask);
`else
    logic unused_irq;
    assign unused_irq = ^{bus.irq, mask, status.ie};
    assign irq_take   = 1'b0;
`endif

    assign exc  = !bus.mem_en_ && (bus.mem_exp_code != EXP_NONE || irq_take);
    assign eret = !bus.mem_en_ && bus.mem_eret;
    assign code = (bus.mem_exp_code != EXP_NONE) ? bus.mem_exp_code
                                                 : EXP_EXT_INT;

    // Mutually exclusive selects encode the RUN-state priority.
    assign sel_busy = busy;
    assign sel_exc  = !busy && exc;
    assign sel_eret = !busy && !exc && eret;
    assign sel_ld   = !busy && !exc && !eret && bus.ld_haz;

    assign run     = (state_q == ST_RUN) && !rst;
    assign trap_go = run && sel_exc;
    assign eret_go = run && sel_eret;

    always_comb begin
        stall  = '0;
        flush  = '0;
        new_pc = '0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    unique case (1'b1)
                        sel_busy: stall = 4'b1111;
                        sel_exc: begin
                            flush  = 4'b1111;
                            new_pc = EXC_VEC;
                        end
                        sel_eret: begin
                            flush  = 4'b1111;
                            new_pc = epc;
                        end
                        sel_ld: begin
                            stall = 4'b1000;
                            flush = 4'b0100;
                        end
                        default: ;
                    endcase
                end
                ST_TRAP, ST_RETURN: stall = 4'b1000;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (trap_go)      state_q <= ST_TRAP;
                    else if (eret_go) state_q <= ST_RETURN;
                end
                ST_TRAP, ST_RETURN: state_q <= ST_RUN;
                default:            state_q <= ST_RUN;
            endcase
        end
    end

    yutorina_exc_spr u_spr (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (!bus.spr_we_ && !busy),
        .waddr_i (bus.spr_w_addr),
        .wdata_i (bus.spr_w_data),
        .trap_i  (trap_go),
        .code_i  (code),
        .pc_i    (bus.mem_pc),
        .eret_i  (eret_go),
        .raddr_i (bus.spr_r_addr),
        .rdata_o (bus.spr_r_data),
        .status_o(status),
        .epc_o   (epc),
        .mask_o  (mask)
    );

    assign {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall} = stall;
    assign {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = flush;
    assign bus.new_pc = new_pc;
    assign bus.mode   = status.mode;

endmodule
